ram_dp_param: RTL and testbench

Parametrised simple-dual-port synchronous RAM: the successor to the single-port RAM, with one write port and one read port usable in the same cycle. Adds per-byte write enables, a selectable 1- or 2-cycle read latency, a selectable read/write collision mode, and a read-valid strobe. Adds out-of-range address flags, and a reset-cleared per-word "written" bitmap so that unwritten words read as zero. Used as the storage element for the RAM testbench environment and for buffering blocks built after it.

---
 rtl/ram_dp_param.sv | 138 +++++++++++++
 tb/tb_ram_dp_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// Simple-dual-port synchronous RAM with one write port and one read port.
// Adds byte enables, a 1- or 2-cycle read latency and a read/write collision mode.
// Out-of-range addresses are flagged. A per-word written bitmap makes
// never-written words read as zero without clearing the array itself.
module ram_dp_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RW_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_enb,
    input  logic                    read_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    rd_err,
    output logic                    wr_err
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      wbit_q;

    logic                  wr_in_range, rd_in_range, wr_ok, collide;
    logic [IdxW-1:0]       wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;

    // Values presented to the output register stage
    logic                  o_valid_d, o_err_d;
    logic [DATA_WIDTH-1:0] o_data_d;

    logic                  data_valid_q, rd_err_q, wr_err_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    assign wr_in_range = ({1'b0, wr_address} < DepthLim);
    assign rd_in_range = ({1'b0, rd_address} < DepthLim);
    assign wr_idx      = wr_address[IdxW-1:0];
    assign rd_idx      = rd_address[IdxW-1:0];
    assign wr_ok       = write_enb & wr_in_range;
    assign collide     = wr_ok & rd_in_range & (wr_address == rd_address);

    // Merge write data into the current word; unwritten words start from zero
    always_comb begin
        wr_old    = wbit_q[wr_idx] ? mem_q[wr_idx] : '0;
        wr_merged = wr_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (byte_enb[i]) begin
                wr_merged[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Read data selection, including collision forwarding in write-first mode
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if ((RW_MODE == 1) && collide) begin
                rd_word = wr_merged;
            end else if (wbit_q[rd_idx]) begin
                rd_word = mem_q[rd_idx];
            end
        end
    end

    // Array storage is never reset; wbit_q masks stale contents instead
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    // Written bitmap, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbit_q <= '0;
        end else if (wr_ok) begin
            wbit_q[wr_idx] <= 1'b1;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  p_valid_q, p_err_q;
        logic [DATA_WIDTH-1:0] p_data_q;

        // Extra read pipeline stage for the 2-cycle latency configuration
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                p_valid_q <= 1'b0;
                p_err_q   <= 1'b0;
                p_data_q  <= '0;
            end else begin
                p_valid_q <= read_enb;
                p_err_q   <= read_enb & ~rd_in_range;
                p_data_q  <= rd_word;
            end
        end

        assign o_valid_d = p_valid_q;
        assign o_err_d   = p_err_q;
        assign o_data_d  = p_data_q;
    end else begin : g_lat1
        assign o_valid_d = read_enb;
        assign o_err_d   = read_enb & ~rd_in_range;
        assign o_data_d  = rd_word;
    end

    // Output registers; data_out only changes when a read result arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            data_valid_q <= o_valid_d;
            rd_err_q     <= o_err_d;
            wr_err_q     <= write_enb & ~wr_in_range;
            if (o_valid_d) begin
                data_out_q <= o_data_d;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign rd_err     = rd_err_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two configurations share one stimulus stream.
// DUT 0: DEPTH=16, RD_LATENCY=1, read-first. DUT 1: DEPTH=12, RD_LATENCY=2, write-first.
module tb_ram_dp_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enb, read_enb;
    logic [3:0]  wr_address, rd_address;
    logic [15:0] data_in;
    logic [1:0]  byte_enb;

    logic [15:0] dout   [2];
    logic        dvalid [2];
    logic        rerr   [2];
    logic        werr   [2];

    always #5 clk = ~clk;

    ram_dp_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1), .RW_MODE(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .write_enb(write_enb), .wr_address(wr_address),
        .data_in(data_in), .byte_enb(byte_enb), .read_enb(read_enb),
        .rd_address(rd_address), .data_out(dout[0]), .data_valid(dvalid[0]),
        .rd_err(rerr[0]), .wr_err(werr[0])
    );

    ram_dp_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2), .RW_MODE(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .write_enb(write_enb), .wr_address(wr_address),
        .data_in(data_in), .byte_enb(byte_enb), .read_enb(read_enb),
        .rd_address(rd_address), .data_out(dout[1]), .data_valid(dvalid[1]),
        .rd_err(rerr[1]), .wr_err(werr[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: word storage, written flags and a small schedule of
    // read results keyed by the cycle they are due to appear.
    logic [15:0] mem_m    [2][16];
    bit          wb_m     [2][16];
    bit          ring_v   [2][4];
    bit          ring_e   [2][4];
    logic [15:0] ring_d   [2][4];
    logic [15:0] exp_dout [2];
    bit          exp_werr [2];

    function automatic int depth_of(int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit wfirst_of(int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16; a++) wb_m[d][a] = 1'b0;
            for (int s = 0; s < 4; s++) ring_v[d][s] = 1'b0;
            exp_dout[d] = 16'h0;
            exp_werr[d] = 1'b0;
        end
    endtask

    task automatic drive(input bit we, input int wa, input logic [15:0] din,
                         input logic [1:0] be, input bit re, input int ra);
        write_enb  = we;
        wr_address = 4'(wa);
        data_in    = din;
        byte_enb   = be;
        read_enb   = re;
        rd_address = 4'(ra);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s dut%0d data_out", tag, d), 32'(dout[d]), 32'h0);
            check_eq($sformatf("%s dut%0d data_valid", tag, d), 32'(dvalid[d]), 32'h0);
            check_eq($sformatf("%s dut%0d rd_err", tag, d), 32'(rerr[d]), 32'h0);
            check_eq($sformatf("%s dut%0d wr_err", tag, d), 32'(werr[d]), 32'h0);
        end
    endtask

    task automatic check_outputs();
        int  slot;
        bit  ev, ee;
        slot = cyc % 4;
        for (int d = 0; d < 2; d++) begin
            ev = ring_v[d][slot];
            ee = ev && ring_e[d][slot];
            if (ev) exp_dout[d] = ring_d[d][slot];
            ring_v[d][slot] = 1'b0;
            check_eq($sformatf("dut%0d data_valid", d), 32'(dvalid[d]), 32'(ev));
            check_eq($sformatf("dut%0d rd_err", d), 32'(rerr[d]), 32'(ee));
            check_eq($sformatf("dut%0d data_out", d), 32'(dout[d]), 32'(exp_dout[d]));
            check_eq($sformatf("dut%0d wr_err", d), 32'(werr[d]), 32'(exp_werr[d]));
        end
    endtask

    // Predict this cycle's effects from the current inputs, clock once, compare.
    task automatic step();
        bit          rd_in, wr_in;
        logic [15:0] old_w, new_w, r;
        int          slot;
        for (int d = 0; d < 2; d++) begin
            rd_in = int'(rd_address) < depth_of(d);
            wr_in = int'(wr_address) < depth_of(d);
            old_w = wb_m[d][wr_address] ? mem_m[d][wr_address] : 16'h0;
            for (int i = 0; i < 2; i++) begin
                new_w[8*i +: 8] = byte_enb[i] ? data_in[8*i +: 8] : old_w[8*i +: 8];
            end
            if (read_enb) begin
                if (!rd_in) r = 16'h0;
                else if (wfirst_of(d) && write_enb && wr_in && wr_address == rd_address)
                    r = new_w;
                else r = wb_m[d][rd_address] ? mem_m[d][rd_address] : 16'h0;
                slot = (cyc + lat_of(d)) % 4;
                ring_v[d][slot] = 1'b1;
                ring_e[d][slot] = !rd_in;
                ring_d[d][slot] = r;
            end
            if (write_enb && wr_in) begin
                mem_m[d][wr_address] = new_w;
                wb_m[d][wr_address]  = 1'b1;
            end
            exp_werr[d] = write_enb && !wr_in;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 16'h0, 2'b00, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        drive(0, 0, 16'h0, 2'b00, 0, 0);
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("reset async");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cyc += 2;
        check_zero("reset held");
        reset = 1'b0;

        // Unwritten words read as zero
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 16'h0, 2'b00, 1, a);
            step();
        end
        idle(2);

        // Byte-enable merge
        drive(1, 3, 16'hA5C3, 2'b11, 0, 0);
        step();
        drive(1, 3, 16'h1200, 2'b10, 0, 0);
        step();
        drive(0, 0, 16'h0, 2'b00, 1, 3);
        step();
        idle(2);

        // Collision on address 5, then a plain read back
        drive(1, 5, 16'h1111, 2'b11, 0, 0);
        step();
        drive(1, 5, 16'h2222, 2'b11, 1, 5);
        step();
        drive(0, 0, 16'h0, 2'b00, 1, 5);
        step();
        idle(2);

        // Out-of-range write and read (only for the 12-word instance)
        drive(1, 13, 16'hFFFF, 2'b11, 0, 0);
        step();
        drive(0, 0, 16'h0, 2'b00, 1, 13);
        step();
        idle(2);
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 16'h0, 2'b00, 1, a);
            step();
        end
        idle(2);

        // Back-to-back reads
        for (int a = 0; a < 4; a++) begin
            drive(1, a, 16'h0100 + 16'(a), 2'b11, 0, 0);
            step();
        end
        for (int a = 0; a < 4; a++) begin
            drive(0, 0, 16'h0, 2'b00, 1, a);
            step();
        end
        idle(2);

        // Reset one cycle after a read: the 2-cycle result must never appear
        drive(0, 0, 16'h0, 2'b00, 1, 3);
        step();
        drive(0, 0, 16'h0, 2'b00, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("mid reset async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_zero("mid reset held");
        end
        reset = 1'b0;
        drive(0, 0, 16'h0, 2'b00, 1, 3);
        step();
        idle(2);

        // Randomized traffic with biased collisions
        for (int i = 0; i < 400; i++) begin
            int wa;
            wa = int'($urandom % 16);
            drive(bit'($urandom % 2), wa, 16'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0),
                  (($urandom % 4) == 0) ? wa : int'($urandom % 16));
            step();
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
